axi_cmd_master: RTL and testbench

AXI4 burst master that sits directly upstream of the memory-mapped AXI4 slave and drives its AW/W/B and AR/R channels. It accepts one command at a time (address, length, size, direction) over a valid/ready command port. Write beats come from a data stream; read beats are forwarded to a data stream. A completion pulse carries the transaction response. Used as the stimulus engine for slave-level and system-level benches.

---
 rtl/axi_cmd_master.sv | 189 ++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_master.sv
// AXI4 burst master: one command at a time, write beats from a stream, read beats to a stream.
// Optional statistics counters are enabled with `define AXI_MST_STATS_EN.
module axi_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
`ifdef AXI_MST_STATS_EN
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_err_cnt,
`endif
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds its payload stable until that edge.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            beat_cnt;
  logic [1:0]            sticky;
  logic [1:0]            resp_max;

  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = size_q;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = size_q;
  assign dbg_state = state;

  // Data channels pass straight through, but only while their phase is active.
  assign WVALID   = (state == S_W) && wr_valid;
  assign WDATA    = (state == S_W) ? wr_data : '0;
  assign wr_ready = (state == S_W) && WREADY;
  assign WLAST    = (state == S_W) && (beat_cnt == len_q);
  assign RREADY   = (state == S_R) && rd_ready;
  assign rd_valid = (state == S_R) && RVALID;
  assign rd_data  = (state == S_R) ? RDATA : '0;
  assign rd_last  = (state == S_R) && RLAST;
  assign resp_max = (RRESP > sticky) ? RRESP : sticky;

`ifdef AXI_MST_STATS_EN
  logic write_q;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_cnt  <= '0;
      sticky    <= '0;
      AWVALID   <= 1'b0;
      ARVALID   <= 1'b0;
      BREADY    <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
`ifdef AXI_MST_STATS_EN
      write_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            size_q   <= cmd_size;
            beat_cnt <= '0;
            sticky   <= '0;
`ifdef AXI_MST_STATS_EN
            write_q  <= cmd_write;
`endif
            if (cmd_size > MAX_SIZE) begin
              done      <= 1'b1;
              done_resp <= 2'b10;
            end else begin
              cmd_ready <= 1'b0;
              if (cmd_write) begin
                AWVALID <= 1'b1;
                state   <= S_AW;
              end else begin
                ARVALID <= 1'b1;
                state   <= S_AR;
              end
            end
          end
        end
        S_AW: if (AWREADY) begin
          AWVALID <= 1'b0;
          state   <= S_W;
        end
        S_W: if (WVALID && WREADY) begin
          if (WLAST) begin
            BREADY <= 1'b1;
            state  <= S_B;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        S_B: if (BVALID) begin
          BREADY    <= 1'b0;
          done      <= 1'b1;
          done_resp <= BRESP;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_AR: if (ARREADY) begin
          ARVALID <= 1'b0;
          state   <= S_R;
        end
        S_R: if (RVALID && RREADY) begin
          sticky <= resp_max;
          if (RLAST) begin
            done      <= 1'b1;
            done_resp <= resp_max;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_MST_STATS_EN
  // Counters follow the done pulse by one cycle and saturate rather than wrap.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (done) begin
      if (write_q && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (!write_q && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (done_resp != 2'b00 && stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_cmd_master.sv
// Bench for axi_cmd_master: behavioural AXI slave with memory, write-stream driver,
// and a monitor that pops expected read beats and completions from queues.
`timescale 1ns/1ps
module tb_axi_cmd_master;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_last, done;
  logic [1:0]    done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE, dbg_state;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;
`ifdef AXI_MST_STATS_EN
  logic [15:0]   stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  axi_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
`ifdef AXI_MST_STATS_EN
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_rd_q[$];
  logic [1:0]  exp_done_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] mem [0:1023];
  bit          wr_gap = 1'b0;
  int          aw_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          r_err_beat = -1;
  logic [1:0]  r_err_resp = 2'b00;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_len = '0;
  int          acc_cyc = 0, hs_cyc = 0;
  int          aw_rises = 0, ar_rises = 0;
  int          w_beat = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {53'd0, cmd_ready, wr_ready, rd_valid, rd_last, done, AWVALID,
                          WVALID, WLAST, BREADY, ARVALID, RREADY}, 64'd0);
    check({tag, "_data"}, {rd_data, WDATA}, 64'd0);
    check({tag, "_aw"}, {AWADDR, AWLEN, AWSIZE}, 64'd0);
    check({tag, "_ar"}, {ARADDR, ARLEN, ARSIZE}, 64'd0);
    check({tag, "_resp_state"}, {done_resp, dbg_state}, 64'd0);
`ifdef AXI_MST_STATS_EN
    check({tag, "_stats"}, {stat_wr_cnt, stat_rd_cnt, stat_err_cnt}, 64'd0);
`endif
  endtask

  // ---------------- slave model ----------------
  initial begin : slave
    int aw_cnt = 0;
    logic [9:0] w_base = '0;
    logic b_pend = 1'b0;
    logic r_act = 1'b0;
    logic [9:0] r_base = '0;
    int r_beat = 0;
    int r_len = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        aw_cnt = 0; w_beat = 0; b_pend = 0; r_act = 0; r_beat = 0;
      end
      AWREADY = AWVALID && (aw_cnt >= aw_delay);
      WREADY  = 1'b1;
      BVALID  = b_pend;
      BRESP   = b_pend ? b_resp_cfg : 2'b00;
      ARREADY = ARVALID;
      RVALID  = r_act;
      RDATA   = r_act ? mem[r_base + 10'(r_beat)] : '0;
      RLAST   = r_act && (r_beat == r_len);
      RRESP   = (r_act && r_beat == r_err_beat) ? r_err_resp : 2'b00;
      #1;
      if (ARESETn) begin
        if (AWVALID) check("awaddr_len", {AWADDR, AWLEN, AWSIZE}, {exp_addr, exp_len, 3'd2});
        if (AWVALID && !AWREADY) aw_cnt++;
        if (AWVALID && AWREADY) begin
          w_base = AWADDR[11:2]; w_beat = 0; aw_cnt = 0;
        end
        if (WVALID && WREADY) begin
          mem[w_base + 10'(w_beat)] = WDATA;
          check("wlast", 64'(WLAST), 64'(w_beat == int'(exp_len)));
          if (WLAST) b_pend = 1'b1;
          w_beat++;
        end
        if (BVALID && BREADY) begin
          b_pend = 1'b0; hs_cyc = cyc;
        end
        if (ARVALID && ARREADY) begin
          check("araddr_len", {ARADDR, ARLEN, ARSIZE}, {exp_addr, exp_len, 3'd2});
          r_base = ARADDR[11:2]; r_len = int'(ARLEN); r_beat = 0; r_act = 1'b1;
        end
        if (RVALID && RREADY) begin
          if (RLAST) begin
            r_act = 1'b0; hs_cyc = cyc;
          end
          r_beat++;
        end
      end
    end
  end

  // ---------------- write-stream driver ----------------
  initial begin : wr_drv
    bit tog = 1'b0;
    wr_valid = 1'b0; wr_data = '0;
    forever begin
      @(negedge ACLK);
      tog = ~tog;
      if (wr_q.size() > 0 && (!wr_gap || tog)) begin
        wr_valid = 1'b1; wr_data = wr_q[0];
      end else begin
        wr_valid = 1'b0; wr_data = '0;
      end
      #1;
      if (wr_valid && wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic aw_prev = 1'b0;
    logic ar_prev = 1'b0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETn) begin
        aw_prev = 1'b0; ar_prev = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          acc_cyc = cyc;
          if (cmd_size > 3'd2) hs_cyc = cyc;
        end
        if (AWVALID && !aw_prev) begin
          aw_rises++; check("aw_latency", 64'(cyc), 64'(acc_cyc + 1));
        end
        if (ARVALID && !ar_prev) begin
          ar_rises++; check("ar_latency", 64'(cyc), 64'(acc_cyc + 1));
        end
        aw_prev = AWVALID; ar_prev = ARVALID;
        if (rd_valid && rd_ready) begin
          if (exp_rd_q.size() == 0) begin
            check("rd_unexpected", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            logic [32:0] e;
            e = exp_rd_q.pop_front();
            check("rd_beat", {31'd0, rd_last, rd_data}, {31'd0, e});
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
          end else begin
            check("done_resp", 64'(done_resp), 64'(exp_done_q.pop_front()));
            check("done_latency", 64'(cyc), 64'(hs_cyc + 1));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l,
                          input logic [2:0] s);
    int t = 0;
    exp_addr = a; exp_len = l;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s;
    #1;
    while (!cmd_ready && t < 200) begin
      @(negedge ACLK); #1; t++;
    end
    if (t >= 200) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((exp_done_q.size() != 0 || exp_rd_q.size() != 0) && t < limit) begin
      @(negedge ACLK); #2; t++;
    end
    if (t >= limit) begin
      check("completion_timeout", 64'(exp_done_q.size() + exp_rd_q.size()), 64'd0);
      exp_done_q.delete(); exp_rd_q.delete();
    end
    repeat (2) @(negedge ACLK);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int t;
    int a0, r0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; rd_ready = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    repeat (3) @(negedge ACLK);
    #1 check_all_zero("reset");
    @(negedge ACLK);
    ARESETn = 1'b1; rd_ready = 1'b1;

    // T1: write 1..4 at 0x0010
    for (int i = 1; i <= 4; i++) wr_q.push_back(32'(i));
    exp_done_q.push_back(2'b00);
    send_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
    wait_idle(200);
    for (int i = 0; i < 4; i++) check("t1_mem", 64'(mem[4 + i]), 64'(i + 1));

    // T2: read it back
    for (int i = 1; i <= 4; i++) exp_rd_q.push_back({(i == 4), 32'(i)});
    exp_done_q.push_back(2'b00);
    send_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
    wait_idle(200);

    // T3: single beat, AWREADY stalled 5 cycles, gapped write stream
    aw_delay = 5; wr_gap = 1'b1;
    wr_q.push_back(32'hDEAD_BEEF);
    exp_done_q.push_back(2'b00);
    send_cmd(1'b1, 16'h0040, 8'd0, 3'd2);
    wait_idle(200);
    check("t3_mem", 64'(mem[16]), 64'hDEAD_BEEF);
    aw_delay = 0; wr_gap = 1'b0;

    // T4: read len=2 with SLVERR on beat 1
    r_err_beat = 1; r_err_resp = 2'b10;
    for (int i = 0; i < 3; i++) exp_rd_q.push_back({(i == 2), 32'hA000_0040 + 32'(i)});
    exp_done_q.push_back(2'b10);
    send_cmd(1'b0, 16'h0100, 8'd2, 3'd2);
    wait_idle(200);
    r_err_beat = -1; r_err_resp = 2'b00;

    // T5: oversize rejected without bus traffic
    a0 = aw_rises; r0 = ar_rises;
    exp_done_q.push_back(2'b10);
    send_cmd(1'b1, 16'h0080, 8'd0, 3'd3);
    wait_idle(50);
    check("t5_no_aw", 64'(aw_rises), 64'(a0));
    check("t5_no_ar", 64'(ar_rises), 64'(r0));
`ifdef AXI_MST_STATS_EN
    check("t5_err_cnt", 64'(stat_err_cnt), 64'd2);
`endif

    // T6: reset during beat 2 of a len=7 write, then a clean len=0 write
    for (int i = 0; i < 8; i++) wr_q.push_back(32'h0000_0100 + 32'(i));
    send_cmd(1'b1, 16'h0200, 8'd7, 3'd2);
    t = 0;
    while (w_beat < 2 && t < 100) begin
      @(negedge ACLK); #2; t++;
    end
    check("t6_reached_beat2", 64'(w_beat), 64'd2);
    #1 ARESETn = 1'b0;
    #1 check_all_zero("midreset");
    wr_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    wr_q.push_back(32'h5555_AAAA);
    exp_done_q.push_back(2'b00);
    send_cmd(1'b1, 16'h0060, 8'd0, 3'd2);
    wait_idle(200);
    check("t6_mem", 64'(mem[24]), 64'h5555_AAAA);

    // T7: gapped len=3 write, then read back
    wr_gap = 1'b1;
    for (int i = 0; i < 4; i++) wr_q.push_back(32'hC0 + 32'(i));
    exp_done_q.push_back(2'b00);
    send_cmd(1'b1, 16'h0030, 8'd3, 3'd2);
    wait_idle(200);
    wr_gap = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd_q.push_back({(i == 3), 32'hC0 + 32'(i)});
    exp_done_q.push_back(2'b00);
    send_cmd(1'b0, 16'h0030, 8'd3, 3'd2);
    wait_idle(200);

    // T8: 256-beat write, BRESP=01
    b_resp_cfg = 2'b01;
    for (int i = 0; i < 256; i++) wr_q.push_back(32'h1000 + 32'(i));
    exp_done_q.push_back(2'b01);
    send_cmd(1'b1, 16'h0400, 8'd255, 3'd2);
    wait_idle(1000);
    b_resp_cfg = 2'b00;
    for (int i = 0; i < 256; i++) check("t8_mem", 64'(mem[256 + i]), 64'(32'h1000 + i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
